// File: rtl/song_player.sv
// Autonomous note sequencer: walks a song stored in an external synchronous ROM
// and drives the one-hot notes vector and octave code consumed by the sound engine.
module song_player #(
    parameter int unsigned UNIT_CYCLES = 6250000,
    parameter int unsigned GAP_CYCLES  = 1000000,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [7:0]        notes,
    output logic [1:0]        octave,
    output logic              busy,
    output logic              paused,
    output logic              done
);

    // The counter serves both note durations and the articulation gap.
    localparam int unsigned DUR_MAX = 63 * UNIT_CYCLES;
    localparam int unsigned CNT_MAX = (DUR_MAX > GAP_CYCLES) ? DUR_MAX : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] UNIT_C   = CNT_W'(UNIT_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_GAP,
        S_END,
        S_PAUSED
    } state_t;

    state_t            state, state_d;
    state_t            saved_state, saved_state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              fetch_phase, fetch_phase_d;
    logic              pause_pend, pause_pend_d;
    logic [ADDR_W-1:0] rom_addr_d;
    logic [7:0]        lat_notes, lat_notes_d;
    logic [1:0]        lat_oct, lat_oct_d;
    logic              done_d;

    logic [7:0] notes_d;
    logic [1:0] octave_d;
    logic       busy_d;
    logic       paused_d;

    logic [7:0] rd_notes;
    logic [1:0] rd_oct;
    logic [5:0] rd_dur;

    assign rd_notes = rom_data[15:8];
    assign rd_oct   = (rom_data[7:6] == 2'b11) ? 2'b00 : rom_data[7:6];
    assign rd_dur   = rom_data[5:0];

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d       = state;
        saved_state_d = saved_state;
        cnt_d         = cnt;
        fetch_phase_d = fetch_phase;
        pause_pend_d  = pause_pend;
        rom_addr_d    = rom_addr;
        lat_notes_d   = lat_notes;
        lat_oct_d     = lat_oct;
        done_d        = 1'b0;

        if (stop && state != S_IDLE) begin
            state_d       = S_IDLE;
            rom_addr_d    = '0;
            cnt_d         = '0;
            fetch_phase_d = 1'b0;
            pause_pend_d  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_d       = S_FETCH;
                        rom_addr_d    = '0;
                        fetch_phase_d = 1'b0;
                    end
                end

                S_FETCH: begin
                    if (pause) begin
                        pause_pend_d = 1'b1;
                    end
                    if (!fetch_phase) begin
                        fetch_phase_d = 1'b1;
                    end else begin
                        fetch_phase_d = 1'b0;
                        if (rd_dur == 6'd0) begin
                            state_d = S_END;
                        end else begin
                            lat_notes_d = rd_notes;
                            lat_oct_d   = rd_oct;
                            cnt_d       = CNT_W'(rd_dur) * UNIT_C - CNT_W'(1);
                            state_d     = S_PLAY;
                        end
                    end
                end

                S_PLAY: begin
                    // A pause held over from FETCH lands here before any count is consumed.
                    if (pause || pause_pend) begin
                        saved_state_d = S_PLAY;
                        state_d       = S_PAUSED;
                        pause_pend_d  = 1'b0;
                    end else if (cnt == '0) begin
                        if (GAP_CYCLES == 0) begin
                            rom_addr_d = rom_addr + ADDR_W'(1);
                            state_d    = S_FETCH;
                        end else begin
                            cnt_d   = GAP_LOAD;
                            state_d = S_GAP;
                        end
                    end else begin
                        cnt_d = cnt - CNT_W'(1);
                    end
                end

                S_GAP: begin
                    if (pause) begin
                        saved_state_d = S_GAP;
                        state_d       = S_PAUSED;
                    end else if (cnt == '0) begin
                        rom_addr_d = rom_addr + ADDR_W'(1);
                        state_d    = S_FETCH;
                    end else begin
                        cnt_d = cnt - CNT_W'(1);
                    end
                end

                S_END: begin
                    // An empty song never loops, otherwise loop_en would refetch forever.
                    rom_addr_d    = '0;
                    fetch_phase_d = 1'b0;
                    if (rom_addr == '0 || !loop_en) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end

                S_PAUSED: begin
                    if (pause) begin
                        state_d = saved_state;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Sound outputs trail the state by one register stage.
        notes_d  = (state == S_PLAY && state_d != S_PAUSED && state_d != S_IDLE) ? lat_notes : 8'h00;
        octave_d = (state == S_PLAY) ? lat_oct : octave;
        busy_d   = (state_d != S_IDLE);
        paused_d = (state_d == S_PAUSED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            saved_state <= S_IDLE;
            cnt         <= '0;
            fetch_phase <= 1'b0;
            pause_pend  <= 1'b0;
            rom_addr    <= '0;
            lat_notes   <= 8'h00;
            lat_oct     <= 2'b00;
            notes       <= 8'h00;
            octave      <= 2'b00;
            busy        <= 1'b0;
            paused      <= 1'b0;
            done        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state       <= state_d;
            saved_state <= saved_state_d;
            cnt         <= cnt_d;
            fetch_phase <= fetch_phase_d;
            pause_pend  <= pause_pend_d;
            rom_addr    <= rom_addr_d;
            lat_notes   <= lat_notes_d;
            lat_oct     <= lat_oct_d;
            notes       <= notes_d;
            octave      <= octave_d;
            busy        <= busy_d;
            paused      <= paused_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_song_player.sv
// Directed bench for song_player: per-cycle expected outputs and input pulses are
// queued as the scenario is written, then popped and compared cycle by cycle.
module tb_song_player;

    localparam int unsigned ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic              pause;
    logic              loop_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [7:0]        notes;
    logic [1:0]        octave;
    logic              busy;
    logic              paused;
    logic              done;

    logic [15:0] rom_mem [4];

    song_player #(
        .UNIT_CYCLES(4),
        .GAP_CYCLES (2),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .loop_en (loop_en),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .notes   (notes),
        .octave  (octave),
        .busy    (busy),
        .paused  (paused),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data for an address is present one edge after the address.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    typedef struct packed {
        logic [7:0] notes;
        logic [1:0] octave;
        logic       busy;
        logic       paused;
        logic       done;
        logic [1:0] addr;
    } obs_t;

    typedef struct {
        string      tag;
        obs_t       v;
        logic [3:0] ctl;   // {rst, start, stop, pause} driven during this cycle
    } exp_t;

    localparam logic [3:0] C_NONE  = 4'b0000;
    localparam logic [3:0] C_PAUSE = 4'b0001;
    localparam logic [3:0] C_STOP  = 4'b0010;
    localparam logic [3:0] C_START = 4'b0100;
    localparam logic [3:0] C_RST   = 4'b1000;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input int n, input logic [7:0] nt, input logic [1:0] oc,
                        input logic b, input logic p, input logic d, input logic [1:0] a,
                        input logic [3:0] ctl);
        exp_t e;
        e.tag = tag;
        e.v   = {nt, oc, b, p, d, a};
        e.ctl = ctl;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        obs_t obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = {notes, octave, busy, paused, done, rom_addr};
            checks++;
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.v);
            end
            {rst, start, stop, pause} = e.ctl;
            @(posedge clk);
            #1;
        end
        {rst, start, stop, pause} = C_NONE;
    endtask

    logic [7:0] n5 [4];
    logic [1:0] o5 [4];
    logic [1:0] prev_oct;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        pause   = 1'b0;
        loop_en = 1'b0;
        rom_mem[0] = 16'h0185;
        rom_mem[1] = 16'h8041;
        rom_mem[2] = 16'h0000;
        rom_mem[3] = 16'h0000;
        repeat (3) @(posedge clk);
        #1;

        // Reset values, then release
        push("reset", 2, 8'h00, 2'b00, 0, 0, 0, 2'd0, C_NONE);
        drain();

        // 1: two-note song, no loop
        push("t1_idle",   1,  8'h00, 2'b00, 0, 0, 0, 2'd0, C_START);
        push("t1_fetch0", 3,  8'h00, 2'b00, 1, 0, 0, 2'd0, C_NONE);
        push("t1_note0",  20, 8'h01, 2'b10, 1, 0, 0, 2'd0, C_NONE);
        push("t1_gap0",   1,  8'h00, 2'b10, 1, 0, 0, 2'd0, C_NONE);
        push("t1_fetch1", 3,  8'h00, 2'b10, 1, 0, 0, 2'd1, C_NONE);
        push("t1_note1",  4,  8'h80, 2'b01, 1, 0, 0, 2'd1, C_NONE);
        push("t1_gap1",   1,  8'h00, 2'b01, 1, 0, 0, 2'd1, C_NONE);
        push("t1_end",    3,  8'h00, 2'b01, 1, 0, 0, 2'd2, C_NONE);
        push("t1_done",   1,  8'h00, 2'b01, 0, 0, 1, 2'd0, C_NONE);
        push("t1_after",  1,  8'h00, 2'b01, 0, 0, 0, 2'd0, C_NONE);
        drain();

        // 2: loop back to entry 0 without done, then stop mid-note
        loop_en = 1'b1;
        push("t2_idle",    1,  8'h00, 2'b01, 0, 0, 0, 2'd0, C_START);
        push("t2_fetch0",  3,  8'h00, 2'b01, 1, 0, 0, 2'd0, C_NONE);
        push("t2_note0",   20, 8'h01, 2'b10, 1, 0, 0, 2'd0, C_NONE);
        push("t2_gap0",    1,  8'h00, 2'b10, 1, 0, 0, 2'd0, C_NONE);
        push("t2_fetch1",  3,  8'h00, 2'b10, 1, 0, 0, 2'd1, C_NONE);
        push("t2_note1",   4,  8'h80, 2'b01, 1, 0, 0, 2'd1, C_NONE);
        push("t2_gap1",    1,  8'h00, 2'b01, 1, 0, 0, 2'd1, C_NONE);
        push("t2_end",     3,  8'h00, 2'b01, 1, 0, 0, 2'd2, C_NONE);
        push("t2_refetch", 3,  8'h00, 2'b01, 1, 0, 0, 2'd0, C_NONE);
        push("t2_replay",  4,  8'h01, 2'b10, 1, 0, 0, 2'd0, C_NONE);
        push("t2_replay",  1,  8'h01, 2'b10, 1, 0, 0, 2'd0, C_STOP);
        push("t2_stopped", 1,  8'h00, 2'b10, 0, 0, 0, 2'd0, C_NONE);
        drain();
        loop_en = 1'b0;

        // 3: pause 5 cycles into note 0, hold 50 cycles, resume for the remaining 15
        push("t3_idle",    1,  8'h00, 2'b10, 0, 0, 0, 2'd0, C_START);
        push("t3_fetch0",  3,  8'h00, 2'b10, 1, 0, 0, 2'd0, C_NONE);
        push("t3_note_a",  4,  8'h01, 2'b10, 1, 0, 0, 2'd0, C_NONE);
        push("t3_note_a",  1,  8'h01, 2'b10, 1, 0, 0, 2'd0, C_PAUSE);
        push("t3_hold",    49, 8'h00, 2'b10, 1, 1, 0, 2'd0, C_NONE);
        push("t3_hold",    1,  8'h00, 2'b10, 1, 1, 0, 2'd0, C_PAUSE);
        push("t3_resume",  1,  8'h00, 2'b10, 1, 0, 0, 2'd0, C_NONE);
        push("t3_note_b",  15, 8'h01, 2'b10, 1, 0, 0, 2'd0, C_NONE);
        push("t3_gap0",    1,  8'h00, 2'b10, 1, 0, 0, 2'd0, C_STOP);
        push("t3_stopped", 1,  8'h00, 2'b10, 0, 0, 0, 2'd0, C_NONE);
        drain();

        // 4: empty song with loop_en set ends at once; pause in IDLE ignored
        rom_mem[0] = 16'h0000;
        loop_en    = 1'b1;
        push("t4_idle",   1, 8'h00, 2'b10, 0, 0, 0, 2'd0, C_START);
        push("t4_fetch",  3, 8'h00, 2'b10, 1, 0, 0, 2'd0, C_NONE);
        push("t4_done",   1, 8'h00, 2'b10, 0, 0, 1, 2'd0, C_NONE);
        push("t4_idle2",  1, 8'h00, 2'b10, 0, 0, 0, 2'd0, C_PAUSE);
        push("t4_norefetch", 6, 8'h00, 2'b10, 0, 0, 0, 2'd0, C_NONE);
        drain();
        loop_en = 1'b0;

        // 5: full four-entry song wraps 3 -> 0; octave field 11 plays as 00
        rom_mem[0] = 16'h02C1;
        rom_mem[1] = 16'h0481;
        rom_mem[2] = 16'h0841;
        rom_mem[3] = 16'h3001;
        n5[0] = 8'h02; o5[0] = 2'b00;
        n5[1] = 8'h04; o5[1] = 2'b10;
        n5[2] = 8'h08; o5[2] = 2'b01;
        n5[3] = 8'h30; o5[3] = 2'b00;
        prev_oct = 2'b10;
        push("t5_idle", 1, 8'h00, prev_oct, 0, 0, 0, 2'd0, C_START);
        for (int i = 0; i < 4; i++) begin
            push($sformatf("t5_fetch%0d", i), 3, 8'h00, prev_oct, 1, 0, 0, 2'(i), C_NONE);
            push($sformatf("t5_note%0d", i),  4, n5[i], o5[i],    1, 0, 0, 2'(i), C_NONE);
            push($sformatf("t5_gap%0d", i),   1, 8'h00, o5[i],    1, 0, 0, 2'(i), C_NONE);
            prev_oct = o5[i];
        end
        push("t5_wrap_fetch", 3, 8'h00, prev_oct, 1, 0, 0, 2'd0, C_NONE);
        push("t5_wrap_note",  1, n5[0], o5[0],    1, 0, 0, 2'd0, C_NONE);
        push("t5_wrap_note",  1, n5[0], o5[0],    1, 0, 0, 2'd0, C_STOP);
        push("t5_stopped",    1, 8'h00, o5[0],    0, 0, 0, 2'd0, C_NONE);
        drain();

        // 6: start while busy is ignored; reset mid-PLAY clears everything
        rom_mem[0] = 16'h0185;
        push("t6_idle",   1, 8'h00, 2'b00, 0, 0, 0, 2'd0, C_START);
        push("t6_fetch",  1, 8'h00, 2'b00, 1, 0, 0, 2'd0, C_NONE);
        push("t6_fetch",  1, 8'h00, 2'b00, 1, 0, 0, 2'd0, C_START);
        push("t6_fetch",  1, 8'h00, 2'b00, 1, 0, 0, 2'd0, C_NONE);
        push("t6_note",   2, 8'h01, 2'b10, 1, 0, 0, 2'd0, C_NONE);
        push("t6_note",   1, 8'h01, 2'b10, 1, 0, 0, 2'd0, C_START);
        push("t6_note",   3, 8'h01, 2'b10, 1, 0, 0, 2'd0, C_NONE);
        push("t6_note",   1, 8'h01, 2'b10, 1, 0, 0, 2'd0, C_RST);
        push("t6_reset",  2, 8'h00, 2'b00, 0, 0, 0, 2'd0, C_NONE);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
